// File: rtl/loader_sequencer.sv
// ---------------------------------------------------------------------------
// loader_sequencer
//
// Purpose:
//    Takes a configuration-load command (target region, start offset, word
//    count) and then streams that many data words, one at a time, to a
//    downstream configuration loader. Each word is presented on ADDRESS /
//    DATA_OUT and qualified by a SELECT_LEVEL strobe that stays high for
//    STROBE_CYCLES cycles, followed by GAP_CYCLES low cycles before the next
//    word is requested. The word offset advances by one per word and wraps
//    inside the region. The region field never changes during a command.
//
//    Regions: 0..NB_SLAVES-1 are BLE slaves, NB_SLAVES is DMSB,
//    NB_SLAVES+1 is UMSB and NB_SLAVES+2 is DMSBOUT. Any higher region code,
//    or a zero word count, is rejected with a one-cycle ERR pulse.
//
// Ports:
//    CLK           sole clock, rising edge
//    RESET         synchronous, active-high reset
//    CMD_VALID     command present
//    CMD_READY     high only while idle; command taken on VALID & READY
//    CMD_REGION    target region code (REGION_W bits)
//    CMD_OFFSET    start word offset within the region (OFFSET_W bits)
//    CMD_COUNT     number of words to load (OFFSET_W+1 bits)
//    DIN_VALID     data word present
//    DIN_READY     high only while waiting for the next data word
//    DIN           data word (DATA_SIZE bits)
//    ABORT         drop the current command (ignored while idle)
//    SELECT_LEVEL  load strobe level towards the downstream loader
//    ADDRESS       {region, offset} of the current word
//    DATA_OUT      current word
//    BUSY          high whenever a command is in progress
//    DONE          one-cycle pulse after the last word's gap
//    ERR           one-cycle pulse when a command is rejected
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module loader_sequencer #(
   parameter int ADDRESS_SIZE  = 10,
   parameter int DATA_SIZE     = 8,
   parameter int NB_SLAVES     = 4,
   parameter int STROBE_CYCLES = 2,
   parameter int GAP_CYCLES    = 1,
   localparam int REGION_W     = $clog2(NB_SLAVES + 2),
   localparam int OFFSET_W     = ADDRESS_SIZE - REGION_W
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic [REGION_W-1:0]     CMD_REGION,
   input  logic [OFFSET_W-1:0]     CMD_OFFSET,
   input  logic [OFFSET_W:0]       CMD_COUNT,
   input  logic                    DIN_VALID,
   output logic                    DIN_READY,
   input  logic [DATA_SIZE-1:0]    DIN,
   input  logic                    ABORT,
   output logic                    SELECT_LEVEL,
   output logic [ADDRESS_SIZE-1:0] ADDRESS,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    ERR
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_DATA = 2'd1;
   localparam logic [1:0] ST_STROBE    = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;

   // Phase counter reload values: the counter runs down to zero, so a phase
   // of N cycles is loaded with N-1.
   localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

   localparam logic [OFFSET_W-1:0] OFFSET_ONE = OFFSET_W'(1);
   localparam logic [OFFSET_W:0]   COUNT_ONE  = (OFFSET_W + 1)'(1);

   // Highest region code that addresses a real target (DMSBOUT).
   localparam int REGION_MAX = NB_SLAVES + 2;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]            state;
   logic [3:0]            phase_cnt;
   logic [OFFSET_W:0]     remaining;
   logic [REGION_W-1:0]   region_q;
   logic [OFFSET_W-1:0]   offset_q;

   // ------------------------------------------------------------------------
   // Decode helpers
   // ------------------------------------------------------------------------
   logic                  cmd_accept;
   logic                  cmd_bad;
   logic                  word_accept;
   logic                  phase_done;
   logic                  last_word;
   logic                  abort_now;
   logic [OFFSET_W-1:0]   offset_next;

   // Qualify the two handshakes with the registered READY flags so that a
   // transfer happens exactly when the outside world sees VALID & READY.
   // The offset wraps naturally at OFFSET_W bits, which keeps the region
   // field of ADDRESS untouched when a load runs past the end of a region.
   always_comb begin
      cmd_accept  = CMD_VALID && CMD_READY;
      cmd_bad     = (int'(CMD_REGION) > REGION_MAX) || (CMD_COUNT == '0);
      word_accept = DIN_VALID && DIN_READY;
      phase_done  = (phase_cnt == '0);
      last_word   = (remaining == COUNT_ONE);
      abort_now   = ABORT && (state != ST_IDLE);
      offset_next = offset_q + OFFSET_ONE;
   end

   // ------------------------------------------------------------------------
   // Main sequencer
   //
   // Reset clears everything, including the command handshake, so CMD_READY
   // only rises on the first edge after reset is released. ABORT outranks
   // any handshake in the same cycle but leaves ADDRESS/DATA_OUT holding the
   // last presented word. DONE and ERR default low so they only ever pulse
   // for one cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= ST_IDLE;
         phase_cnt    <= '0;
         remaining    <= '0;
         region_q     <= '0;
         offset_q     <= '0;
         CMD_READY    <= 1'b0;
         DIN_READY    <= 1'b0;
         SELECT_LEVEL <= 1'b0;
         ADDRESS      <= '0;
         DATA_OUT     <= '0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         ERR          <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;

         if (abort_now) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            remaining    <= '0;
            CMD_READY    <= 1'b1;
            DIN_READY    <= 1'b0;
            SELECT_LEVEL <= 1'b0;
            BUSY         <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  CMD_READY <= 1'b1;
                  if (cmd_accept) begin
                     if (cmd_bad) begin
                        ERR <= 1'b1;
                     end else begin
                        region_q  <= CMD_REGION;
                        offset_q  <= CMD_OFFSET;
                        remaining <= CMD_COUNT;
                        ADDRESS   <= {CMD_REGION, CMD_OFFSET};
                        CMD_READY <= 1'b0;
                        DIN_READY <= 1'b1;
                        BUSY      <= 1'b1;
                        state     <= ST_WAIT_DATA;
                     end
                  end
               end

               ST_WAIT_DATA: begin
                  if (word_accept) begin
                     DATA_OUT     <= DIN;
                     SELECT_LEVEL <= 1'b1;
                     DIN_READY    <= 1'b0;
                     phase_cnt    <= STROBE_LAST;
                     state        <= ST_STROBE;
                  end
               end

               ST_STROBE: begin
                  if (phase_done) begin
                     SELECT_LEVEL <= 1'b0;
                     phase_cnt    <= GAP_LAST;
                     state        <= ST_GAP;
                  end else begin
                     phase_cnt <= phase_cnt - 4'd1;
                  end
               end

               ST_GAP: begin
                  if (phase_done) begin
                     remaining <= remaining - COUNT_ONE;
                     if (last_word) begin
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                     end else begin
                        offset_q  <= offset_next;
                        ADDRESS   <= {region_q, offset_next};
                        DIN_READY <= 1'b1;
                        state     <= ST_WAIT_DATA;
                     end
                  end else begin
                     phase_cnt <= phase_cnt - 4'd1;
                  end
               end

               default: begin
                  state        <= ST_IDLE;
                  CMD_READY    <= 1'b1;
                  DIN_READY    <= 1'b0;
                  SELECT_LEVEL <= 1'b0;
                  BUSY         <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_loader_sequencer.sv
// ---------------------------------------------------------------------------
// tb_loader_sequencer
//
// Purpose:
//    Directed bench for loader_sequencer. A behavioural model describes each
//    word as a timeline measured from its data handshake (strobe for the
//    first STROBE_CYCLES cycles, gap for the next GAP_CYCLES) and predicts
//    every output on every cycle. Literal expectations for the reference
//    scenarios pin the model itself.
// ---------------------------------------------------------------------------
module tb_loader_sequencer;

   localparam int ADDRESS_SIZE  = 10;
   localparam int DATA_SIZE     = 8;
   localparam int NB_SLAVES     = 4;
   localparam int STROBE_CYCLES = 2;
   localparam int GAP_CYCLES    = 1;
   localparam int REGION_W      = $clog2(NB_SLAVES + 2);
   localparam int OFFSET_W      = ADDRESS_SIZE - REGION_W;

   logic                    CLK = 1'b0;
   logic                    RESET = 1'b1;
   logic                    CMD_VALID = 1'b0;
   logic                    CMD_READY;
   logic [REGION_W-1:0]     CMD_REGION = '0;
   logic [OFFSET_W-1:0]     CMD_OFFSET = '0;
   logic [OFFSET_W:0]       CMD_COUNT = '0;
   logic                    DIN_VALID = 1'b0;
   logic                    DIN_READY;
   logic [DATA_SIZE-1:0]    DIN = '0;
   logic                    ABORT = 1'b0;
   logic                    SELECT_LEVEL;
   logic [ADDRESS_SIZE-1:0] ADDRESS;
   logic [DATA_SIZE-1:0]    DATA_OUT;
   logic                    BUSY;
   logic                    DONE;
   logic                    ERR;

   int tests_run = 0;
   int tests_failed = 0;
   bit check_en = 1'b0;

   always #5 CLK = ~CLK;

   loader_sequencer #(
      .ADDRESS_SIZE (ADDRESS_SIZE),
      .DATA_SIZE    (DATA_SIZE),
      .NB_SLAVES    (NB_SLAVES),
      .STROBE_CYCLES(STROBE_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .CMD_VALID   (CMD_VALID),
      .CMD_READY   (CMD_READY),
      .CMD_REGION  (CMD_REGION),
      .CMD_OFFSET  (CMD_OFFSET),
      .CMD_COUNT   (CMD_COUNT),
      .DIN_VALID   (DIN_VALID),
      .DIN_READY   (DIN_READY),
      .DIN         (DIN),
      .ABORT       (ABORT),
      .SELECT_LEVEL(SELECT_LEVEL),
      .ADDRESS     (ADDRESS),
      .DATA_OUT    (DATA_OUT),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .ERR         (ERR)
   );

   // One comparison: counts it, and reports it on a mismatch.
   task automatic check_output(input string name, input logic [31:0] got,
                               input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model. A command is "active" from acceptance until its last
   // word finishes. While active it is either waiting for a word, or m_t
   // cycles into the current word's strobe+gap timeline.
   // ------------------------------------------------------------------------
   bit                     m_active = 0;
   bit                     m_waiting = 0;
   bit                     m_cmd_ready = 0;
   bit                     m_done = 0;
   bit                     m_err = 0;
   int                     m_t = 0;
   int                     m_left = 0;
   logic [REGION_W-1:0]    m_region = '0;
   logic [OFFSET_W-1:0]    m_offset = '0;
   logic [DATA_SIZE-1:0]   m_data = '0;

   always @(posedge CLK) begin
      if (RESET) begin
         m_active = 0; m_waiting = 0; m_cmd_ready = 0; m_done = 0; m_err = 0;
         m_t = 0; m_left = 0; m_region = '0; m_offset = '0; m_data = '0;
      end else begin
         m_done = 0;
         m_err  = 0;
         if (m_active) begin
            if (ABORT) begin
               m_active = 0;
            end else if (m_waiting) begin
               if (DIN_VALID) begin
                  m_data    = DIN;
                  m_waiting = 0;
                  m_t       = 0;
               end
            end else begin
               m_t++;
               if (m_t == STROBE_CYCLES + GAP_CYCLES) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_active = 0;
                     m_done   = 1;
                  end else begin
                     m_offset  = OFFSET_W'((int'(m_offset) + 1) % (1 << OFFSET_W));
                     m_waiting = 1;
                  end
               end
            end
         end else if (m_cmd_ready && CMD_VALID) begin
            if (int'(CMD_REGION) > NB_SLAVES + 2 || CMD_COUNT == 0) begin
               m_err = 1;
            end else begin
               m_region  = CMD_REGION;
               m_offset  = CMD_OFFSET;
               m_left    = int'(CMD_COUNT);
               m_active  = 1;
               m_waiting = 1;
            end
         end
         m_cmd_ready = !m_active;
      end
   end

   // ------------------------------------------------------------------------
   // Per-cycle compare against the model on the falling edge, plus logs of
   // presented words, strobe widths and gap widths for literal checks.
   // ------------------------------------------------------------------------
   logic [ADDRESS_SIZE-1:0] addr_log[$];
   logic [DATA_SIZE-1:0]    data_log[$];
   int                      hi_runs[$];
   int                      gap_runs[$];
   int                      hi_run = 0;
   int                      gap_run = 0;
   int                      done_cnt = 0;
   int                      err_cnt = 0;
   bit                      busy_seen = 0;
   logic                    prev_sel = 1'b0;

   always @(negedge CLK) begin
      if (check_en) begin
         check_output("select_level", 32'(SELECT_LEVEL),
                      32'(m_active && !m_waiting && (m_t < STROBE_CYCLES)));
         check_output("address", 32'(ADDRESS), 32'({m_region, m_offset}));
         check_output("data_out", 32'(DATA_OUT), 32'(m_data));
         check_output("busy", 32'(BUSY), 32'(m_active));
         check_output("din_ready", 32'(DIN_READY), 32'(m_active && m_waiting));
         check_output("cmd_ready", 32'(CMD_READY), 32'(m_cmd_ready));
         check_output("done", 32'(DONE), 32'(m_done));
         check_output("err", 32'(ERR), 32'(m_err));

         if (SELECT_LEVEL === 1'b1 && prev_sel !== 1'b1) begin
            addr_log.push_back(ADDRESS);
            data_log.push_back(DATA_OUT);
         end
         prev_sel = SELECT_LEVEL;

         if (SELECT_LEVEL === 1'b1) hi_run++;
         else if (hi_run > 0) begin hi_runs.push_back(hi_run); hi_run = 0; end

         if (BUSY === 1'b1 && SELECT_LEVEL === 1'b0 && DIN_READY === 1'b0) gap_run++;
         else if (gap_run > 0) begin gap_runs.push_back(gap_run); gap_run = 0; end

         if (DONE === 1'b1) done_cnt++;
         if (ERR === 1'b1) err_cnt++;
         if (BUSY === 1'b1) busy_seen = 1;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus tasks; all are entered and left on a falling edge.
   // ------------------------------------------------------------------------
   task automatic send_cmd(input int region, input int offset, input int count);
      int waited = 0;
      while (CMD_READY !== 1'b1 && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      if (waited >= 50) check_output("cmd_ready_timeout", 0, 1);
      CMD_REGION = REGION_W'(region);
      CMD_OFFSET = OFFSET_W'(offset);
      CMD_COUNT  = (OFFSET_W + 1)'(count);
      CMD_VALID  = 1'b1;
      @(negedge CLK);
      CMD_VALID  = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_SIZE-1:0] value, input int delay);
      int waited = 0;
      while (DIN_READY !== 1'b1 && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      if (waited >= 50) check_output("din_ready_timeout", 0, 1);
      repeat (delay) @(negedge CLK);
      DIN       = value;
      DIN_VALID = 1'b1;
      @(negedge CLK);
      DIN_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      int waited = 0;
      while (BUSY !== 1'b0 && waited < 200) begin
         @(negedge CLK);
         waited++;
      end
      if (waited >= 200) check_output("busy_timeout", 0, 1);
      @(negedge CLK);
   endtask

   task automatic clear_logs();
      addr_log.delete();
      data_log.delete();
      hi_runs.delete();
      gap_runs.delete();
      busy_seen = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_select"}, 32'(SELECT_LEVEL), 0);
      check_output({tag, "_address"}, 32'(ADDRESS), 0);
      check_output({tag, "_data"}, 32'(DATA_OUT), 0);
      check_output({tag, "_din_ready"}, 32'(DIN_READY), 0);
      check_output({tag, "_busy"}, 32'(BUSY), 0);
      check_output({tag, "_done"}, 32'(DONE), 0);
      check_output({tag, "_err"}, 32'(ERR), 0);
      check_output({tag, "_cmd_ready"}, 32'(CMD_READY), 0);
   endtask

   // ------------------------------------------------------------------------
   // Directed scenarios
   // ------------------------------------------------------------------------
   initial begin
      int done0;
      int err0;
      logic [ADDRESS_SIZE-1:0] exp_a[3];
      logic [DATA_SIZE-1:0]    exp_d[3];

      // Reset state and release
      RESET = 1'b1;
      @(negedge CLK);
      check_en = 1'b1;
      @(negedge CLK);
      check_reset_outputs("reset");
      RESET = 1'b0;
      @(negedge CLK);
      check_output("release_cmd_ready", 32'(CMD_READY), 1);

      // Three words into region 4 starting at offset 5
      clear_logs();
      done0 = done_cnt;
      exp_a = '{10'h205, 10'h206, 10'h207};
      exp_d = '{8'hA1, 8'hB2, 8'hC3};
      send_cmd(4, 5, 3);
      send_word(8'hA1, 0);
      send_word(8'hB2, 0);
      send_word(8'hC3, 0);
      wait_idle();
      check_output("basic_words", addr_log.size(), 3);
      for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
         check_output("basic_addr", 32'(addr_log[i]), 32'(exp_a[i]));
         check_output("basic_data", 32'(data_log[i]), 32'(exp_d[i]));
      end
      check_output("basic_strobes", hi_runs.size(), 3);
      foreach (hi_runs[i]) check_output("basic_strobe_len", hi_runs[i], 2);
      check_output("basic_gaps", gap_runs.size(), 3);
      foreach (gap_runs[i]) check_output("basic_gap_len", gap_runs[i], 1);
      check_output("basic_done", done_cnt - done0, 1);

      // Rejected commands: bad region, then zero count
      clear_logs();
      err0 = err_cnt;
      send_cmd(7, 0, 1);
      send_cmd(0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      check_output("reject_err", err_cnt - err0, 2);
      check_output("reject_words", addr_log.size(), 0);
      check_output("reject_busy", 32'(busy_seen), 0);

      // Offset wrap inside region 1
      clear_logs();
      send_cmd(1, 127, 2);
      send_word(8'h11, 0);
      send_word(8'h22, 0);
      wait_idle();
      check_output("wrap_words", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         check_output("wrap_addr0", 32'(addr_log[0]), 32'h0FF);
         check_output("wrap_addr1", 32'(addr_log[1]), 32'h080);
      end

      // Data withheld for ten cycles
      clear_logs();
      send_cmd(2, 10, 2);
      send_word(8'h3C, 10);
      send_word(8'h4D, 0);
      wait_idle();
      check_output("stall_words", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         check_output("stall_addr0", 32'(addr_log[0]), 32'h10A);
         check_output("stall_addr1", 32'(addr_log[1]), 32'h10B);
         check_output("stall_data0", 32'(data_log[0]), 32'h3C);
      end

      // Abort in the second strobe cycle of word 2 of 4
      clear_logs();
      done0 = done_cnt;
      send_cmd(3, 0, 4);
      send_word(8'h01, 0);
      send_word(8'h02, 0);
      @(negedge CLK);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      check_output("abort_select", 32'(SELECT_LEVEL), 0);
      check_output("abort_busy", 32'(BUSY), 0);
      check_output("abort_cmd_ready", 32'(CMD_READY), 1);
      @(negedge CLK);
      check_output("abort_done", done_cnt - done0, 0);
      check_output("abort_strobes", hi_runs.size(), 2);
      if (hi_runs.size() == 2) check_output("abort_strobe_len", hi_runs[1], 2);

      // New command accepted afterwards, with ABORT ignored while idle
      clear_logs();
      done0 = done_cnt;
      ABORT = 1'b1;
      send_cmd(5, 3, 1);
      ABORT = 1'b0;
      send_word(8'h5A, 0);
      wait_idle();
      check_output("post_abort_words", addr_log.size(), 1);
      if (addr_log.size() == 1) check_output("post_abort_addr", 32'(addr_log[0]), 32'h283);
      check_output("post_abort_done", done_cnt - done0, 1);

      // Reset during the gap, with ABORT also high
      done0 = done_cnt;
      send_cmd(0, 0, 2);
      send_word(8'h77, 0);
      repeat (2) @(negedge CLK);
      check_output("gap_select", 32'(SELECT_LEVEL), 0);
      check_output("gap_busy", 32'(BUSY), 1);
      check_output("gap_din_ready", 32'(DIN_READY), 0);
      RESET = 1'b1;
      ABORT = 1'b1;
      @(negedge CLK);
      check_reset_outputs("midreset");
      RESET = 1'b0;
      ABORT = 1'b0;
      @(negedge CLK);
      check_output("midreset_release_ready", 32'(CMD_READY), 1);
      check_output("midreset_done", done_cnt - done0, 0);

      // Maximum-length command visits every offset of region 6 once
      clear_logs();
      done0 = done_cnt;
      send_cmd(6, 100, 1 << OFFSET_W);
      for (int i = 0; i < (1 << OFFSET_W); i++) send_word(DATA_SIZE'(i), 0);
      wait_idle();
      check_output("max_words", addr_log.size(), 1 << OFFSET_W);
      for (int i = 0; i < addr_log.size(); i++) begin
         check_output("max_addr", 32'(addr_log[i]),
                      (32'd6 << OFFSET_W) | 32'((100 + i) % (1 << OFFSET_W)));
      end
      check_output("max_done", done_cnt - done0, 1);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Guards against a stuck run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/loader_sequencer.md
LOADER_SEQUENCER -- requirements
Module: loader_sequencer

Interface
REQ-001 Parameter ADDRESS_SIZE, default 10, width of ADDRESS output.
REQ-002 Parameter DATA_SIZE, default 8, width of configuration data words.
REQ-003 Parameter NB_SLAVES, default 4, number of BLE slave regions.
REQ-004 Parameter STROBE_CYCLES, default 2, range 1..15, cycles SELECT_LEVEL is held high per word.
REQ-005 Parameter GAP_CYCLES, default 1, range 1..15, cycles SELECT_LEVEL is held low between words.
REQ-006 Derived widths SHALL be REGION_W = clog2(NB_SLAVES+2) and OFFSET_W = ADDRESS_SIZE-REGION_W; NB_SLAVES+2 < 2^REGION_W is required.
REQ-007 CLK  in  1  sole clock; all logic on rising edge.
REQ-008 RESET  in  1  synchronous, active-high reset.
REQ-009 CMD_VALID  in  1  command present.
REQ-010 CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
REQ-011 CMD_REGION  in  REGION_W  target: 0..NB_SLAVES-1 BLE, NB_SLAVES DMSB, NB_SLAVES+1 UMSB, NB_SLAVES+2 DMSBOUT.
REQ-012 CMD_OFFSET  in  OFFSET_W  start word offset within region.
REQ-013 CMD_COUNT  in  OFFSET_W+1  number of words to load.
REQ-014 DIN_VALID / DIN_READY  in / out  1 / 1  data word handshake.
REQ-015 DIN  in  DATA_SIZE  configuration data word.
REQ-016 ABORT  in  1  synchronous abort of current command.
REQ-017 SELECT_LEVEL  out  1  load strobe level to downstream loader.
REQ-018 ADDRESS  out  ADDRESS_SIZE  {region, offset} of current word.
REQ-019 DATA_OUT  out  DATA_SIZE  current word.
REQ-020 BUSY  out  1  high in every state except IDLE.
REQ-021 DONE / ERR  out / out  1 / 1  single-cycle completion / rejection pulses.

Function
REQ-022 FSM states SHALL be IDLE, WAIT_DATA, STROBE, GAP; all outputs registered.
REQ-023 CMD_READY SHALL be high only in IDLE; DIN_READY high only in WAIT_DATA.
REQ-024 IDLE: on command handshake with CMD_REGION > NB_SLAVES+2 or CMD_COUNT = 0, command SHALL be discarded, ERR pulsed next cycle, state stays IDLE.
REQ-025 IDLE: on valid command, region, offset and count SHALL be latched, ADDRESS = {CMD_REGION, CMD_OFFSET} next cycle, state -> WAIT_DATA.
REQ-026 WAIT_DATA: on DIN handshake, DATA_OUT <= DIN, SELECT_LEVEL <= 1, state -> STROBE; no handshake keeps state indefinitely with SELECT_LEVEL 0.
REQ-027 STROBE: SELECT_LEVEL SHALL stay high exactly STROBE_CYCLES cycles, ADDRESS and DATA_OUT stable, then SELECT_LEVEL <= 0, state -> GAP.
REQ-028 GAP: SELECT_LEVEL low exactly GAP_CYCLES cycles with ADDRESS held; then remaining count decremented.
REQ-029 GAP exit with remaining > 0: offset SHALL increment modulo 2^OFFSET_W (region field never changes), state -> WAIT_DATA.
REQ-030 GAP exit with remaining = 0: DONE pulsed one cycle, state -> IDLE, ADDRESS and DATA_OUT hold last values.
REQ-031 ADDRESS SHALL never change while SELECT_LEVEL is high.
REQ-032 ABORT in any non-IDLE state: next cycle SELECT_LEVEL 0, state IDLE, no DONE, no ERR; ABORT in IDLE ignored; ABORT has priority over handshakes in same cycle.
REQ-033 Maximum command CMD_COUNT = 2^OFFSET_W SHALL visit every offset once, wrapping.

Reset
REQ-034 RESET high at a clock edge SHALL force state IDLE, SELECT_LEVEL 0, ADDRESS 0, DATA_OUT 0, DIN_READY 0, BUSY 0, DONE 0, ERR 0, counters 0.
REQ-035 CMD_READY SHALL be 0 while RESET is high and 1 on the first cycle after release.
REQ-036 RESET mid-command SHALL discard all progress identically to REQ-034, overriding ABORT.

Verification
REQ-037 Cmd region 4, offset 5, count 3, data A1,B2,C3 -> ADDRESS 0x205,0x206,0x207; SELECT_LEVEL high 2 cycles each, low 1 between; one DONE.
REQ-038 Cmd region 7 count 1, then region 0 count 0 -> ERR pulse each, no SELECT_LEVEL, BUSY stays 0.
REQ-039 Cmd region 1 offset 127 count 2 -> ADDRESS 0x0FF then 0x080 (wrap, region kept).
REQ-040 DIN_VALID withheld 10 cycles in WAIT_DATA -> SELECT_LEVEL 0, ADDRESS stable, resumes normally.
REQ-041 ABORT during second STROBE cycle of word 2 of 4 -> SELECT_LEVEL 0 next cycle, IDLE, no DONE; new command accepted.
REQ-042 RESET asserted in GAP -> all outputs at reset values next cycle; CMD_READY 1 after release.
